// File: rtl/exp6_pkg.sv
// rtl/exp6_pkg.sv - state encoding shared by the exp6 control unit and its bench
package exp6_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_exp6.sv
// rtl/unidade_controle_exp6.sv - Moore control unit sequencing the memory-sequence game
module unidade_controle_exp6
    import exp6_pkg::*;
#(
    parameter logic TIMEOUT_ON = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       fimRod,
    input  logic       fimE,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;

    // fimE is exported by the datapath for debug only
    logic fim_e_unused;
    assign fim_e_unused = fimE;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIA_RODADA;
            INICIA_RODADA:  proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // a play arriving together with the timeout still counts
                if (jogada_feita)
                    proximo = REGISTRA;
                else if (fimT && TIMEOUT_ON)
                    proximo = FIM_TIMEOUT;
                else
                    proximo = ESPERA_JOGADA;
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    proximo = FIM_ERROU;
                else if (enderecoIgualRodada && fimRod)
                    proximo = FIM_ACERTOU;
                else if (enderecoIgualRodada)
                    proximo = PROXIMA_RODADA;
                else
                    proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = INICIA_RODADA;
            FIM_ACERTOU:    proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:      proximo = iniciar ? PREPARACAO : FIM_ERROU;
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraRod   = 1'b0;
        contaRod  = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
            end
            INICIA_RODADA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA:  contaT    = TIMEOUT_ON;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            PROXIMA_RODADA: contaRod = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// tb/tb_unidade_controle_exp6.sv - randomized scoreboard bench for unidade_controle_exp6
module tb_unidade_controle_exp6;
    import exp6_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0, jogada_feita = 1'b0, igual = 1'b0;
    logic enderecoIgualRodada = 1'b0, fimRod = 1'b0, fimE = 1'b0, fimT = 1'b0;

    logic [11:0] o_t, o_n;
    logic [3:0]  st_t, st_n;

    always #5 clock = ~clock;

    unidade_controle_exp6 #(.TIMEOUT_ON(1'b1)) dut_t (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .enderecoIgualRodada(enderecoIgualRodada), .fimRod(fimRod),
        .fimE(fimE), .fimT(fimT),
        .zeraE(o_t[11]), .contaE(o_t[10]), .zeraRod(o_t[9]), .contaRod(o_t[8]),
        .zeraT(o_t[7]), .contaT(o_t[6]), .zeraR(o_t[5]), .registraR(o_t[4]),
        .pronto(o_t[3]), .acertou(o_t[2]), .errou(o_t[1]), .timeout(o_t[0]),
        .db_estado(st_t)
    );

    unidade_controle_exp6 #(.TIMEOUT_ON(1'b0)) dut_n (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .enderecoIgualRodada(enderecoIgualRodada), .fimRod(fimRod),
        .fimE(fimE), .fimT(fimT),
        .zeraE(o_n[11]), .contaE(o_n[10]), .zeraRod(o_n[9]), .contaRod(o_n[8]),
        .zeraT(o_n[7]), .contaT(o_n[6]), .zeraR(o_n[5]), .registraR(o_n[4]),
        .pronto(o_n[3]), .acertou(o_n[2]), .errou(o_n[1]), .timeout(o_n[0]),
        .db_estado(st_n)
    );

    int errors = 0;
    int checks = 0;

    // Expected output word per state code, bit order as wired above
    function automatic logic [11:0] expected_outs(input logic [3:0] s, input bit to_on);
        logic [11:0] w;
        w = 12'h000;
        if (s == 4'h1) w = 12'b1010_1010_0000;
        if (s == 4'h2) w = 12'b1000_1000_0000;
        if (s == 4'h3) w = to_on ? 12'b0000_0100_0000 : 12'h000;
        if (s == 4'h4) w = 12'b0000_0001_0000;
        if (s == 4'h6) w = 12'b0100_1000_0000;
        if (s == 4'h7) w = 12'b0001_0000_0000;
        if (s == 4'hA) w = 12'b0000_0000_1100;
        if (s == 4'hD) w = 12'b0000_0000_1001;
        if (s == 4'hE) w = 12'b0000_0000_1010;
        return w;
    endfunction

    // Game rules written as a transition relation over state codes
    function automatic logic [3:0] next_code(input logic [3:0] s, input bit to_on,
                                             input bit ini, input bit jf, input bit ig,
                                             input bit eir, input bit fr, input bit ft);
        bit idle_or_over;
        idle_or_over = (s == 4'h0) || (s == 4'hA) || (s == 4'hD) || (s == 4'hE);
        if (idle_or_over) return ini ? 4'h1 : s;
        if (s == 4'h1 || s == 4'h7) return 4'h2;
        if (s == 4'h2 || s == 4'h6) return 4'h3;
        if (s == 4'h3) return jf ? 4'h4 : ((ft && to_on) ? 4'hD : 4'h3);
        if (s == 4'h4) return 4'h5;
        if (s == 4'h5) begin
            if (!ig) return 4'hE;
            if (!eir) return 4'h6;
            return fr ? 4'hA : 4'h7;
        end
        return 4'h0;
    endfunction

    logic [15:0] exp_q_t[$];
    logic [15:0] exp_q_n[$];
    logic [3:0]  m_t = 4'h0, m_n = 4'h0;
    bit          started = 1'b0;
    int          visits[16];

    // Reference model: advance on each edge from the sampled inputs, queue expectations
    always @(posedge clock) begin
        if (reset) begin
            m_t = 4'h0;
            m_n = 4'h0;
            started = 1'b1;
        end else if (started) begin
            m_t = next_code(m_t, 1'b1, iniciar, jogada_feita, igual, enderecoIgualRodada, fimRod, fimT);
            m_n = next_code(m_n, 1'b0, iniciar, jogada_feita, igual, enderecoIgualRodada, fimRod, fimT);
        end
        if (started) begin
            visits[m_t] = visits[m_t] + 1;
            exp_q_t.push_back({m_t, expected_outs(m_t, 1'b1)});
            exp_q_n.push_back({m_n, expected_outs(m_n, 1'b0)});
        end
    end

    // Monitor: compare DUT outputs on the falling edge against queued expectations
    always @(negedge clock) begin
        logic [15:0] e;
        if (exp_q_t.size() > 0) begin
            e = exp_q_t.pop_front();
            checks = checks + 1;
            if ({st_t, o_t} !== e) begin
                errors = errors + 1;
                $display("FAIL state_outs_timeout_on: got st=%h outs=%b, want st=%h outs=%b at %0t",
                         st_t, o_t, e[15:12], e[11:0], $time);
            end
        end
        if (exp_q_n.size() > 0) begin
            e = exp_q_n.pop_front();
            checks = checks + 1;
            if ({st_n, o_n} !== e) begin
                errors = errors + 1;
                $display("FAIL state_outs_timeout_off: got st=%h outs=%b, want st=%h outs=%b at %0t",
                         st_n, o_n, e[15:12], e[11:0], $time);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clock);
            #1;
            reset               = ($urandom_range(0, 79) == 0);
            iniciar             = ($urandom_range(0, 5) == 0);
            jogada_feita        = ($urandom_range(0, 2) == 0);
            fimT                = ($urandom_range(0, 7) == 0);
            igual               = ($urandom_range(0, 9) != 0);
            enderecoIgualRodada = ($urandom_range(0, 2) == 0);
            fimRod              = ($urandom_range(0, 3) == 0);
            fimE                = $urandom_range(0, 1) == 1;
        end
        @(posedge clock);
        #1 reset = 1'b0;
        iniciar = 1'b0;
        jogada_feita = 1'b0;
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle_exp6.md
# unidade_controle_exp6

Moore control unit for the memory-sequence game. It drives the round/address counters, the play register, the timeout counter and the edge detector reset in the game datapath. It consumes that datapath's status flags (`fimE`, `fimRod`, `fimT`, `igual`, `enderecoIgualRodada`, `jogada_feita`) and sequences a full game: growing rounds, per-play timeout, and win/lose/timeout terminal states.

## Interface
Parameters:
- `TIMEOUT_ON`, default 1: when 0, `fimT` is ignored and `contaT` stays low.

Ports:
- `clock`  in  1  system clock, all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; forces state `inicial`.
- `iniciar`  in  1  level; starts a game from `inicial` or any terminal state.
- `jogada_feita`  in  1  one-cycle pulse from the datapath edge detector.
- `igual`  in  1  registered play equals the memory word at the current address.
- `enderecoIgualRodada`  in  1  address counter equals round counter.
- `fimRod`  in  1  round counter at 15 (last round).
- `fimE`  in  1  address counter at 15; debug only, not used for decisions.
- `fimT`  in  1  timeout counter reached terminal count.
- `zeraE`, `contaE`, `zeraRod`, `contaRod`, `zeraT`, `contaT`, `zeraR`, `registraR`  out  1 each  datapath controls.
- `pronto`  out  1  game over (any terminal state).
- `acertou`  out  1  game won.
- `errou`  out  1  wrong play.
- `timeout`  out  1  play not made in time.
- `db_estado`  out  4  current state code.

## Operation
State codes:
- `inicial` 0x0: all outputs 0. Goes to `preparacao` when `iniciar`=1.
- `preparacao` 0x1: `zeraE`, `zeraRod`, `zeraR`, `zeraT`. Goes to `inicia_rodada` unconditionally.
- `inicia_rodada` 0x2: `zeraE`, `zeraT`. Goes to `espera_jogada`.
- `espera_jogada` 0x3: `contaT` (if `TIMEOUT_ON`).
  - If `jogada_feita`=1: go to `registra`.
  - Else if `fimT`=1 and `TIMEOUT_ON`: go to `fim_timeout`.
  - Otherwise stay.
- `registra` 0x4: `registraR`. Goes to `comparacao`.
- `comparacao` 0x5, decided in this priority:
  - `igual`=0: go to `fim_errou`.
  - `enderecoIgualRodada`=1 and `fimRod`=1: go to `fim_acertou`.
  - `enderecoIgualRodada`=1: go to `proxima_rodada`.
  - Otherwise: go to `proxima_jogada`.
- `proxima_jogada` 0x6: `contaE`, `zeraT`. Goes to `espera_jogada`.
- `proxima_rodada` 0x7: `contaRod`. Goes to `inicia_rodada`.
- `fim_acertou` 0xA: `pronto`, `acertou`.
- `fim_timeout` 0xD: `pronto`, `timeout`.
- `fim_errou` 0xE: `pronto`, `errou`.
- Terminal states hold until `iniciar`=1, then go to `preparacao`. Counters and register are not cleared before that.
- Unused codes go to `inicial` on the next edge.
- `db_estado` equals the state register.

## Timing
- Outputs are pure decode of the state register (Moore). There is no input-to-output combinational path.
- Reset: state becomes 0x0 at the first rising edge with `reset`=1. All outputs are 0 from that edge. This applies mid-game, including in terminal states.
- `reset` has priority over every input.
- `iniciar` is sampled only in `inicial` and in terminal states; elsewhere it is ignored.
- Start latency: `iniciar` sampled at edge N gives `preparacao` at N, `inicia_rodada` at N+1, `espera_jogada` at N+2.
- Play latency: `jogada_feita` sampled at edge K gives `registra` at K, `comparacao` at K+1, next state at K+2. The next `espera_jogada` is at K+3 via `proxima_jogada`, or K+4 via `proxima_rodada`.
- `jogada_feita` and `fimT` high in the same cycle: the play wins, no timeout.
- `jogada_feita` pulses outside `espera_jogada` are dropped.
- Every control output is high for exactly one cycle per visit, except `contaT` and the terminal flags.
- Round r (0..15) requires r+1 plays. A full win is 136 plays.

## Structure
- Shared package `exp6_pkg` holds the 4-bit state encoding constants above, so the bench and top level decode `db_estado` with the same values.
- Single module with a state register, a next-state block and an output decode. No sub-modules.
- Top level `circuito_exp6` instantiates this unit and the datapath, and wires like-named signals.

## Test plan
- Reset mid-game in `comparacao`, then `reset`=1 for one edge: `db_estado`=0x0 and all outputs 0 on the next cycle.
- `iniciar`, then correct play 0x1 for round 0, `fimRod`=0: states 1,2,3,4,5,7,2,3; `contaRod` high exactly one cycle.
- Round 2, plays with `igual`=1 and `enderecoIgualRodada`=0,0,1: `contaE` pulses twice, then `contaRod` once.
- Wrong play (`igual`=0) in `comparacao`: `db_estado`=0xE, `pronto`=`errou`=1, held until `iniciar`; then `db_estado`=0x1.
- In `espera_jogada`, `fimT`=1 with no play: 0xD with `timeout`=1. Repeat with `jogada_feita`=`fimT`=1 in the same cycle: goes to 0x4. Repeat with `TIMEOUT_ON`=0: stays in 0x3.
- `fimRod`=1, `enderecoIgualRodada`=1, `igual`=1 in `comparacao`: 0xA with `acertou`=`pronto`=1. A `jogada_feita` pulse while in 0xA leaves the state unchanged.
